// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// EXEC_FORWARDING_EN enables the ForwardA_E/ForwardB_E operand muxes.
module execute_cycle #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidE,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              StallM,
  input  logic              FlushE,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              ValidM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] ALU_ResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  logic [DATA_W-1:0] fwd_a, fwd_b, src_b, alu_result;
  logic              zero, advance;

  logic              valid_q, reg_write_q, mem_write_q, result_src_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_result_q, write_data_q, pc_plus4_q;

`ifdef EXEC_FORWARDING_EN
  always_comb begin
    case (ForwardA_E)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = alu_result_q;
      default: fwd_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase
  end
`else
  // Forward selects stay on the port list so the hazard unit wiring is unchanged.
  logic [3:0] unused_fwd;
  assign unused_fwd = {ForwardA_E, ForwardB_E};
  logic [DATA_W-1:0] unused_result_w;
  assign unused_result_w = ResultW;
  assign fwd_a = RD1_E;
  assign fwd_b = RD2_E;
`endif

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = fwd_a + src_b;
      3'b001:  alu_result = fwd_a - src_b;
      3'b010:  alu_result = fwd_a & src_b;
      3'b011:  alu_result = fwd_a | src_b;
      3'b101:  alu_result[0] = ($signed(fwd_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCTargetE = PCE + Imm_Ext_E;
  // Gated by StallM so a held branch redirects fetch only once, when it advances.
  assign PCSrcE    = ValidE & BranchE & zero & ~FlushE & ~StallM;
  assign advance   = ValidE & ~FlushE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else if (!StallM) begin
      // Bubbles still carry data fields; only the side-effecting controls are squashed.
      valid_q      <= advance;
      reg_write_q  <= RegWriteE & advance;
      mem_write_q  <= MemWriteE & advance;
      result_src_q <= ResultSrcE;
      rd_q         <= RD_E;
      alu_result_q <= alu_result;
      write_data_q <= fwd_b;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  assign ValidM      = valid_q;
  assign RegWriteM   = reg_write_q;
  assign MemWriteM   = mem_write_q;
  assign ResultSrcM  = result_src_q;
  assign RD_M        = rd_q;
  assign ALU_ResultM = alu_result_q;
  assign WriteDataM  = write_data_q;
  assign PCPlus4M    = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed vectors, literal checks and a reference model.
module tb_execute_cycle;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [AW-1:0] RD_E;
  logic [1:0]    ForwardA_E, ForwardB_E;
  logic          StallM, FlushE;
  logic          PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM;
  logic [DW-1:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [AW-1:0] RD_M;

  int n_tests = 0;
  int n_fail  = 0;

  execute_cycle #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW), .StallM(StallM), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
`ifdef EXEC_FORWARDING_EN
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
`else
    return (sel == 2'd3) ? rf : rf ^ wb ^ wb ^ mem ^ mem;
`endif
  endfunction

  logic          m_valid, m_rw, m_mw, m_rs;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_alu, m_wd, m_pc4;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] a, b;
    if (rst) begin
      m_valid <= 0; m_rw <= 0; m_mw <= 0; m_rs <= 0;
      m_rd <= '0; m_alu <= '0; m_wd <= '0; m_pc4 <= '0;
    end else if (!StallM) begin
      a = pick(ForwardA_E, RD1_E, ResultW, m_alu);
      b = pick(ForwardB_E, RD2_E, ResultW, m_alu);
      m_valid <= ValidE && !FlushE;
      m_rw    <= RegWriteE && ValidE && !FlushE;
      m_mw    <= MemWriteE && ValidE && !FlushE;
      m_rs    <= ResultSrcE;
      m_rd    <= RD_E;
      m_alu   <= alu_f(ALUControlE, a, ALUSrcE ? Imm_Ext_E : b);
      m_wd    <= b;
      m_pc4   <= PCPlus4E;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] a, b, r;
    a = pick(ForwardA_E, RD1_E, ResultW, m_alu);
    b = pick(ForwardB_E, RD2_E, ResultW, m_alu);
    r = alu_f(ALUControlE, a, ALUSrcE ? Imm_Ext_E : b);
    chk("PCSrcE", PCSrcE, ValidE && BranchE && (r == 0) && !FlushE && !StallM);
    chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
    chk("ValidM", ValidM, m_valid);
    chk("RegWriteM", RegWriteM, m_rw);
    chk("MemWriteM", MemWriteM, m_mw);
    chk("ResultSrcM", ResultSrcM, m_rs);
    chk("RD_M", RD_M, m_rd);
    chk("ALU_ResultM", ALU_ResultM, m_alu);
    chk("WriteDataM", WriteDataM, m_wd);
    chk("PCPlus4M", PCPlus4M, m_pc4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ValidE = 1; RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
    RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0; StallM = 0; FlushE = 0;
  endtask

  task automatic do_add();
    clear();
    RD1_E = 5; RD2_E = 7; RegWriteE = 1; RD_E = 3; PCPlus4E = 32'h44;
  endtask

  initial begin
    clear();
    #1 rst = 1;
    tick();
    tick();
    chk("reset ValidM", ValidM, 0);
    chk("reset ALU_ResultM", ALU_ResultM, 0);
    rst = 0;

    // Add
    do_add();
    tick();
    chk("add ALU_ResultM", ALU_ResultM, 12);
    chk("add RD_M", RD_M, 3);
    chk("add RegWriteM", RegWriteM, 1);
    chk("add ValidM", ValidM, 1);

    // Forwarding follow-up
    RD1_E = 0; RD2_E = 32'h33; Imm_Ext_E = 4; ALUSrcE = 1;
    ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'hAA;
    tick();
`ifdef EXEC_FORWARDING_EN
    chk("fwd ALU_ResultM", ALU_ResultM, 16);
    chk("fwd WriteDataM", WriteDataM, 32'hAA);
`else
    chk("nofwd ALU_ResultM", ALU_ResultM, 4);
    chk("nofwd WriteDataM", WriteDataM, 32'h33);
`endif
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 1;
    tick();
    chk("fwd11 ALU_ResultM", ALU_ResultM, 5);

    // Signed slt
    clear();
    ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    tick();
    chk("slt ALU_ResultM", ALU_ResultM, 1);
    RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
    tick();
    chk("slt swap ALU_ResultM", ALU_ResultM, 0);

    // Branch
    clear();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    chk("beq taken PCSrcE", PCSrcE, 1);
    chk("beq PCTargetE", PCTargetE, 32'h120);
    RD2_E = 8;
    #1;
    chk("beq not taken PCSrcE", PCSrcE, 0);
    tick();

    // Stall two cycles with a taken-branch condition present
    RD2_E = 9; StallM = 1;
    #1;
    chk("stall PCSrcE", PCSrcE, 0);
    tick();
    tick();
    chk("stall ALU_ResultM", ALU_ResultM, 1);
    chk("stall ValidM", ValidM, 1);

    // Flush squashes the store but data still loads
    clear();
    FlushE = 1; MemWriteE = 1; RD1_E = 3; RD2_E = 4;
    tick();
    chk("flush MemWriteM", MemWriteM, 0);
    chk("flush ValidM", ValidM, 0);
    chk("flush ALU_ResultM", ALU_ResultM, 7);

    // Stall and flush together hold the register
    clear();
    RD1_E = 2; RD2_E = 2; RegWriteE = 1;
    tick();
    StallM = 1; FlushE = 1; RD1_E = 100;
    tick();
    chk("stall+flush ValidM", ValidM, 1);
    chk("stall+flush ALU_ResultM", ALU_ResultM, 4);

    // Bubble and unused op code
    clear();
    ValidE = 0; RegWriteE = 1; ALUControlE = 3'b100; RD1_E = 6; RD2_E = 6;
    tick();
    chk("bubble ValidM", ValidM, 0);
    chk("bubble RegWriteM", RegWriteM, 0);
    chk("op100 ALU_ResultM", ALU_ResultM, 0);

    // Mixed traffic checked by the model
    for (int i = 0; i < 40; i++) begin
      ValidE = ($urandom_range(0, 7) != 0);
      RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
      ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
      ALUControlE = 3'($urandom);
      RD1_E = $urandom; RD2_E = (i % 3 == 0) ? RD1_E : $urandom;
      Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
      RD_E = 5'($urandom); ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
      StallM = ($urandom_range(0, 4) == 0); FlushE = ($urandom_range(0, 4) == 0);
      tick();
    end

    // Asynchronous reset between clock edges
    do_add();
    tick();
    chk("pre-reset ALU_ResultM", ALU_ResultM, 12);
    #3 rst = 1;
    #1;
    chk("async reset ALU_ResultM", ALU_ResultM, 0);
    chk("async reset ValidM", ValidM, 0);
    chk("async reset RegWriteM", RegWriteM, 0);
    chk("async reset PCPlus4M", PCPlus4M, 0);
    chk("async reset RD_M", RD_M, 0);
    tick();
    rst = 0;
    tick();
    chk("post-reset ALU_ResultM", ALU_ResultM, 12);
    chk("post-reset ValidM", ValidM, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
